// File: rtl/instr_load_sequencer_pkg.sv
// Shared sizing and state encoding for the instruction load sequencer.
// Index width carries one extra bit so a count can equal the buffer depth.
package instr_load_sequencer_pkg;

    localparam int NUM_INSTRUCTIONS  = 8;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int INSTR_WIDTH       = $clog2(NUM_INSTRUCTIONS) + 1;
    localparam int BUF_IDX_WIDTH     = $clog2(NUM_INSTRUCTIONS);

    localparam logic [INSTR_WIDTH-1:0] FULL_COUNT = INSTR_WIDTH'(NUM_INSTRUCTIONS);

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_DRAIN = 2'd2,
        LD_DONE  = 2'd3
    } load_state_e;

endpackage

// File: rtl/instr_load_sequencer_if.sv
// Host-side program stream plus the core-side load port of the sequencer.
interface instr_load_sequencer_if;
    import instr_load_sequencer_pkg::*;

    logic                         host_valid;
    logic                         host_ready;
    logic [INSTRUCTION_WIDTH-1:0] host_instr;
    logic                         host_last;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         load_instruction;
    logic                         loading_complete;
    logic [INSTR_WIDTH-1:0]       loaded_count;
    logic                         err_overflow;

    modport master (
        output host_valid, host_instr, host_last,
        input  host_ready, instruction, load_instruction, loading_complete, loaded_count, err_overflow
    );

    modport slave (
        input  host_valid, host_instr, host_last,
        output host_ready, instruction, load_instruction, loading_complete, loaded_count, err_overflow
    );

endinterface

// File: rtl/instr_load_sequencer.sv
// Buffers a host program, then replays it to the core one word per load slot.
// All outputs are registered; strobe decisions are made one cycle ahead of their appearance.
module instr_load_sequencer
    import instr_load_sequencer_pkg::*;
#(
    parameter int LOAD_GAP = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_load_sequencer_if.slave  bus
);

    localparam int GAP_WIDTH = (LOAD_GAP > 0) ? $clog2(LOAD_GAP + 1) : 1;
    localparam logic [GAP_WIDTH-1:0] GAP_RELOAD = GAP_WIDTH'(LOAD_GAP);

    load_state_e                  state_r;
    load_state_e                  state_next_s;
    logic [INSTRUCTION_WIDTH-1:0] buf_r [NUM_INSTRUCTIONS];
    logic [INSTR_WIDTH-1:0]       wr_ptr_r;
    logic [INSTR_WIDTH-1:0]       rd_ptr_r;
    logic [GAP_WIDTH-1:0]         gap_r;
    logic                         ready_r;
    logic                         load_r;
    logic [INSTRUCTION_WIDTH-1:0] instr_r;
    logic                         complete_r;
    logic                         err_r;

    logic                         xfer_s;
    logic                         overflow_s;
    logic                         fill_exit_s;
    logic                         issue_s;
    logic [INSTR_WIDTH-1:0]       wr_ptr_next_s;
    logic [GAP_WIDTH-1:0]         gap_next_s;
    logic [INSTRUCTION_WIDTH-1:0] rd_data_s;
    logic                         ready_next_s;
    logic                         load_next_s;
    logic [INSTRUCTION_WIDTH-1:0] instr_next_s;
    logic                         complete_next_s;

    assign xfer_s      = (state_r == LD_FILL) && ready_r && bus.host_valid;
    assign overflow_s  = (state_r == LD_FILL) && (wr_ptr_r == FULL_COUNT) && bus.host_valid;
    assign fill_exit_s = (xfer_s && bus.host_last) || overflow_s;
    // The first slot is taken on the way out of FILL so it lands in the first DRAIN cycle.
    assign issue_s     = ((state_r == LD_FILL) && fill_exit_s) ||
                         ((state_r == LD_DRAIN) && (gap_r == {GAP_WIDTH{1'b0}}) && (rd_ptr_r != wr_ptr_r));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LD_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LD_IDLE:  state_next_s = LD_FILL;
            LD_FILL:  state_next_s = fill_exit_s ? LD_DRAIN : LD_FILL;
            LD_DRAIN: state_next_s = (rd_ptr_r == wr_ptr_r) ? LD_DONE : LD_DRAIN;
            LD_DONE:  state_next_s = LD_DONE;
            default:  state_next_s = LD_IDLE;
        endcase
    end

    // Next values of pointers, gap counter and registered outputs
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        if (xfer_s) begin
            wr_ptr_next_s = wr_ptr_r + INSTR_WIDTH'(1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        // A one-word program leaves FILL in the same cycle its word is written.
        if (xfer_s && (wr_ptr_r == rd_ptr_r)) begin
            rd_data_s = bus.host_instr;
        end else begin
            rd_data_s = buf_r[rd_ptr_r[BUF_IDX_WIDTH-1:0]];
        end

        gap_next_s = gap_r;
        if (issue_s) begin
            gap_next_s = GAP_RELOAD;
        end else if ((state_r == LD_DRAIN) && (gap_r != {GAP_WIDTH{1'b0}})) begin
            gap_next_s = gap_r - GAP_WIDTH'(1);
        end else begin
            gap_next_s = gap_r;
        end

        ready_next_s    = (state_next_s == LD_FILL) && (wr_ptr_next_s != FULL_COUNT);
        load_next_s     = issue_s;
        instr_next_s    = issue_s ? rd_data_s : {INSTRUCTION_WIDTH{1'b0}};
        complete_next_s = (state_next_s == LD_DONE);
    end

    // Buffer, pointers, sticky error and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
                buf_r[i] <= {INSTRUCTION_WIDTH{1'b0}};
            end
            wr_ptr_r   <= {INSTR_WIDTH{1'b0}};
            rd_ptr_r   <= {INSTR_WIDTH{1'b0}};
            gap_r      <= {GAP_WIDTH{1'b0}};
            ready_r    <= 1'b0;
            load_r     <= 1'b0;
            instr_r    <= {INSTRUCTION_WIDTH{1'b0}};
            complete_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (xfer_s) begin
                buf_r[wr_ptr_r[BUF_IDX_WIDTH-1:0]] <= bus.host_instr;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + INSTR_WIDTH'(1);
            end
            wr_ptr_r   <= wr_ptr_next_s;
            gap_r      <= gap_next_s;
            ready_r    <= ready_next_s;
            load_r     <= load_next_s;
            instr_r    <= instr_next_s;
            complete_r <= complete_next_s;
            err_r      <= err_r | overflow_s;
        end
    end

    assign bus.host_ready       = ready_r;
    assign bus.instruction      = instr_r;
    assign bus.load_instruction = load_r;
    assign bus.loading_complete = complete_r;
    assign bus.loaded_count     = wr_ptr_r;
    assign bus.err_overflow     = err_r;

endmodule

// File: tb/tb_instr_load_sequencer.sv
// Directed bench for instr_load_sequencer: two instances (LOAD_GAP 0 and 2) share one host stream;
// accepted words go to a scoreboard queue and are popped as strobes appear on the selected instance.
module tb_instr_load_sequencer;
    import instr_load_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hv = 1'b0;
    logic        hl = 1'b0;
    logic [31:0] hi = 32'h0;
    logic        sel = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    logic        mon_ready, mon_load, mon_complete, mon_err;
    logic [31:0] mon_instr;
    logic [3:0]  mon_count;

    always #5 clk = ~clk;

    instr_load_sequencer_if bus0 ();
    instr_load_sequencer_if bus1 ();

    assign bus0.host_valid = hv;
    assign bus0.host_instr = hi;
    assign bus0.host_last  = hl;
    assign bus1.host_valid = hv;
    assign bus1.host_instr = hi;
    assign bus1.host_last  = hl;

    instr_load_sequencer #(.LOAD_GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    instr_load_sequencer #(.LOAD_GAP(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always_comb begin
        mon_ready    = sel ? bus1.host_ready       : bus0.host_ready;
        mon_load     = sel ? bus1.load_instruction : bus0.load_instruction;
        mon_complete = sel ? bus1.loading_complete : bus0.loading_complete;
        mon_err      = sel ? bus1.err_overflow     : bus0.err_overflow;
        mon_instr    = sel ? bus1.instruction      : bus0.instruction;
        mon_count    = sel ? bus1.loaded_count     : bus0.loaded_count;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; hv = 1'b0; hl = 1'b0; hi = 32'h0;
        step();
        check("rst_ready",    64'(mon_ready),    64'd0);
        check("rst_instr",    64'(mon_instr),    64'd0);
        check("rst_load",     64'(mon_load),     64'd0);
        check("rst_complete", 64'(mon_complete), 64'd0);
        check("rst_count",    64'(mon_count),    64'd0);
        check("rst_err",      64'(mon_err),      64'd0);
        reset = 1'b0;
        exp_q.delete();
        step();
        check("fill_ready", 64'(mon_ready), 64'd1);
    endtask

    task automatic push(input logic [31:0] w, input logic last);
        check("push_ready", 64'(mon_ready), 64'd1);
        hv = 1'b1; hi = w; hl = last;
        exp_q.push_back(w);
        step();
        hv = 1'b0; hl = 1'b0; hi = 32'h0;
    endtask

    task automatic idle_garbage(input logic [31:0] w);
        hv = 1'b0; hi = w; hl = 1'b1;
        step();
        hl = 1'b0; hi = 32'h0;
    endtask

    task automatic expect_strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    check("gap_load",     64'(mon_load),     64'd0);
                    check("gap_instr",    64'(mon_instr),    64'd0);
                    check("gap_complete", 64'(mon_complete), 64'd0);
                    step();
                end
            end
            check("strobe_load", 64'(mon_load), 64'd1);
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("strobe_instr", 64'(mon_instr), 64'(exp_q.pop_front()));
            end
            check("strobe_complete", 64'(mon_complete), 64'd0);
            step();
        end
    endtask

    task automatic expect_complete(input int count);
        check("done_load",     64'(mon_load),     64'd0);
        check("done_complete", 64'(mon_complete), 64'd1);
        check("done_instr",    64'(mon_instr),    64'd0);
        check("done_count",    64'(mon_count),    64'(count));
        check("done_sb_empty", 64'(exp_q.size()), 64'd0);
        check("done_ready",    64'(mon_ready),    64'd0);
    endtask

    initial begin
        // Three-word program, no gap
        sel = 1'b0;
        do_reset();
        push(32'hAAAA_0001, 1'b0);
        push(32'hBBBB_0002, 1'b0);
        push(32'hCCCC_0003, 1'b1);
        expect_strobes(3, 0);
        expect_complete(3);
        check("t1_err", 64'(mon_err), 64'd0);

        // Full program with last in the final slot
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(32'h1000_0000 + 32'(i * 17), (i == 7) ? 1'b1 : 1'b0);
        end
        check("t2_ready_after_full", 64'(mon_ready), 64'd0);
        expect_strobes(8, 0);
        expect_complete(8);
        check("t2_err", 64'(mon_err), 64'd0);

        // Overflow: eight words without last, host keeps offering a ninth
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(32'h2000_0000 + 32'(i * 3), 1'b0);
        end
        check("t3_ready_full", 64'(mon_ready), 64'd0);
        hv = 1'b1; hi = 32'hDEAD_0009; hl = 1'b0;
        step();
        expect_strobes(8, 0);
        expect_complete(8);
        check("t3_err", 64'(mon_err), 64'd1);
        hv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("t3_err_sticky", 64'(mon_err), 64'd1);
        check("t3_count_hold", 64'(mon_count), 64'd8);

        // Gap of two idle cycles between strobes
        sel = 1'b1;
        do_reset();
        push(32'h3333_0001, 1'b0);
        push(32'h3333_0002, 1'b1);
        expect_strobes(2, 2);
        expect_complete(2);
        sel = 1'b0;

        // host_valid toggling: unqualified words must not be stored
        do_reset();
        push(32'h4444_0001, 1'b0);
        idle_garbage(32'hBAD0_0001);
        push(32'h4444_0002, 1'b0);
        idle_garbage(32'hBAD0_0002);
        push(32'h4444_0003, 1'b1);
        expect_strobes(3, 0);
        expect_complete(3);

        // Reset mid-drain, then refill with a single word
        do_reset();
        push(32'h5555_0001, 1'b0);
        push(32'h5555_0002, 1'b0);
        push(32'h5555_0003, 1'b0);
        push(32'h5555_0004, 1'b1);
        expect_strobes(2, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("t6_no_complete", 64'(mon_complete), 64'd0);
            check("t6_no_load",     64'(mon_load),     64'd0);
            step();
        end
        push(32'h6666_0001, 1'b1);
        expect_strobes(1, 0);
        expect_complete(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
